// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit feeder.
package uart_pkg;
    localparam int BYTE_W = 8;
    localparam int DEPTH_DEF = 16;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_GAP = 2'd2} state_t;
endpackage

// File: rtl/uart_tx_feeder_if.sv
// uart_tx_feeder_if: write port and transmitter handshake of the feeder.
interface uart_tx_feeder_if
    import uart_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
);
    localparam int ADDR_W = $clog2(DEPTH);
    logic              i_Wr_En;
    logic [BYTE_W-1:0] i_Wr_Byte;
    logic              o_Full;
    logic              o_Empty;
    logic [ADDR_W:0]   o_Count;
    logic              o_Overflow;
    logic              o_Busy;
    logic              o_Tx_DV;
    logic [BYTE_W-1:0] o_Tx_Byte;
    logic              i_Tx_Done;
    modport master (
        output i_Wr_En, i_Wr_Byte, i_Tx_Done,
        input  o_Full, o_Empty, o_Count, o_Overflow, o_Busy, o_Tx_DV, o_Tx_Byte
    );
    modport slave (
        input  i_Wr_En, i_Wr_Byte, i_Tx_Done,
        output o_Full, o_Empty, o_Count, o_Overflow, o_Busy, o_Tx_DV, o_Tx_Byte
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: circular byte FIFO with registered count, full and empty flags.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [BYTE_W-1:0] wr_data,
    output logic [BYTE_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);
    logic [BYTE_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count_n;
    logic              do_push, do_pop;
    // a write against a full buffer is dropped even if a pop frees a slot this cycle
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign count_n = count + (ADDR_W+1)'(do_push) - (ADDR_W+1)'(do_pop);
    assign rd_data = mem[rd_ptr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (do_pop) rd_ptr <= rd_ptr + ADDR_W'(1);
            count <= count_n;
            full  <= count_n == (ADDR_W+1)'(DEPTH);
            empty <= count_n == '0;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffers written bytes and launches them one at a time into the UART transmitter.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input logic              i_Clock,
    input logic              i_Rst_n,
    uart_tx_feeder_if.slave  bus
);
    state_t            state, state_n;
    logic              pop;
    logic [BYTE_W-1:0] rd_data;
    uart_sync_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
        .clk     (i_Clock),
        .rst_n   (i_Rst_n),
        .push    (bus.i_Wr_En),
        .pop     (pop),
        .wr_data (bus.i_Wr_Byte),
        .rd_data (rd_data),
        .full    (bus.o_Full),
        .empty   (bus.o_Empty),
        .count   (bus.o_Count)
    );
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) state <= S_IDLE;
        else state <= state_n;
    end
    // S_GAP covers the cycle the transmitter needs to get back to idle after Done
    always_comb begin
        state_n = (state == S_IDLE) ? (bus.o_Empty ? S_IDLE : S_WAIT) :
                  (state == S_WAIT) ? (bus.i_Tx_Done ? S_GAP : S_WAIT) : S_IDLE;
    end
    always_comb begin
        pop = (state == S_IDLE) & ~bus.o_Empty;
    end
    assign bus.o_Busy = (state != S_IDLE) | ~bus.o_Empty;
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            bus.o_Tx_DV    <= 1'b0;
            bus.o_Tx_Byte  <= '0;
            bus.o_Overflow <= 1'b0;
        end else begin
            bus.o_Tx_DV    <= pop;
            bus.o_Overflow <= bus.i_Wr_En & bus.o_Full;
            if (pop) bus.o_Tx_Byte <= rd_data;
        end
    end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: directed vector table plus hand-written sequences for the feeder.
module tb_uart_tx_feeder;
    typedef struct {
        int          gap;
        logic        wr;
        logic [7:0]  wb;
        logic        done;
        logic [17:0] exp;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   done_cyc = 0;
    int   checks = 0;
    int   errors = 0;
    vec_t vt [15];
    uart_tx_feeder_if #(.DEPTH(16)) bus ();
    uart_tx_feeder #(.DEPTH(16)) dut (.i_Clock(clk), .i_Rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic logic [17:0] pk(input logic dv, input logic [7:0] b, input logic [4:0] c,
                                       input logic e, input logic f, input logic bz, input logic o);
        return {dv, b, c, e, f, bz, o};
    endfunction
    function automatic logic [17:0] act();
        return pk(bus.o_Tx_DV, bus.o_Tx_Byte, bus.o_Count, bus.o_Empty, bus.o_Full, bus.o_Busy, bus.o_Overflow);
    endfunction
    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic [7:0] b);
        bus.i_Wr_En = 1'b1;
        bus.i_Wr_Byte = b;
        tick();
        bus.i_Wr_En = 1'b0;
    endtask
    task automatic pulse_done();
        bus.i_Tx_Done = 1'b1;
        tick();
        bus.i_Tx_Done = 1'b0;
        done_cyc = cyc;
        chk("dv one cycle", bus.o_Tx_DV, 0);
    endtask
    task automatic expect_dv(input logic [7:0] b, input string nm);
        int n = 0;
        while (!bus.o_Tx_DV && n < 20) begin
            tick();
            n++;
        end
        chk({nm, " dv"}, bus.o_Tx_DV, 1);
        chk({nm, " byte"}, bus.o_Tx_Byte, b);
        chk({nm, " done-to-dv"}, cyc - done_cyc, 2);
    endtask
    task automatic drain(input logic [7:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            expect_dv(start + 8'(i), $sformatf("drain %h", start + 8'(i)));
            pulse_done();
        end
    endtask
    task automatic no_dv(input int n, input string nm);
        int seen = 0;
        repeat (n) begin
            tick();
            if (bus.o_Tx_DV) seen++;
        end
        chk(nm, seen, 0);
    endtask
    initial begin
        logic ovf_seen;
        bus.i_Wr_En = 1'b0;
        bus.i_Wr_Byte = 8'h00;
        bus.i_Tx_Done = 1'b0;
        vt[0]  = '{0,  1'b1, 8'hA5, 1'b0, pk(0, 8'h00, 1, 0, 0, 1, 0)};
        vt[1]  = '{0,  1'b0, 8'h00, 1'b0, pk(1, 8'hA5, 0, 1, 0, 1, 0)};
        vt[2]  = '{0,  1'b0, 8'h00, 1'b0, pk(0, 8'hA5, 0, 1, 0, 1, 0)};
        vt[3]  = '{18, 1'b0, 8'h00, 1'b1, pk(0, 8'hA5, 0, 1, 0, 1, 0)};
        vt[4]  = '{0,  1'b0, 8'h00, 1'b0, pk(0, 8'hA5, 0, 1, 0, 0, 0)};
        vt[5]  = '{0,  1'b0, 8'h00, 1'b1, pk(0, 8'hA5, 0, 1, 0, 0, 0)};
        vt[6]  = '{0,  1'b0, 8'h00, 1'b0, pk(0, 8'hA5, 0, 1, 0, 0, 0)};
        vt[7]  = '{0,  1'b1, 8'h3C, 1'b1, pk(0, 8'hA5, 1, 0, 0, 1, 0)};
        vt[8]  = '{0,  1'b1, 8'hC3, 1'b0, pk(1, 8'h3C, 1, 0, 0, 1, 0)};
        vt[9]  = '{0,  1'b0, 8'h00, 1'b0, pk(0, 8'h3C, 1, 0, 0, 1, 0)};
        vt[10] = '{0,  1'b0, 8'h00, 1'b1, pk(0, 8'h3C, 1, 0, 0, 1, 0)};
        vt[11] = '{0,  1'b0, 8'h00, 1'b0, pk(0, 8'h3C, 1, 0, 0, 1, 0)};
        vt[12] = '{0,  1'b0, 8'h00, 1'b0, pk(1, 8'hC3, 0, 1, 0, 1, 0)};
        vt[13] = '{0,  1'b0, 8'h00, 1'b1, pk(0, 8'hC3, 0, 1, 0, 1, 0)};
        vt[14] = '{0,  1'b0, 8'h00, 1'b0, pk(0, 8'hC3, 0, 1, 0, 0, 0)};
        repeat (2) tick();
        chk("reset state", act(), pk(0, 8'h00, 0, 1, 0, 0, 0));
        rst_n = 1'b1;
        tick();
        // single byte, stray Done and write/launch overlap
        for (int i = 0; i < 15; i++) begin
            bus.i_Wr_En = 1'b0;
            bus.i_Tx_Done = 1'b0;
            repeat (vt[i].gap) tick();
            bus.i_Wr_En = vt[i].wr;
            bus.i_Wr_Byte = vt[i].wb;
            bus.i_Tx_Done = vt[i].done;
            tick();
            chk($sformatf("vec%0d", i), act(), vt[i].exp);
        end
        bus.i_Wr_En = 1'b0;
        bus.i_Tx_Done = 1'b0;
        // burst of 16: first byte launches during the burst, 15 stay queued
        ovf_seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr(8'(i + 1));
            ovf_seen = ovf_seen | bus.o_Overflow;
            if (i == 1) chk("burst first byte", {bus.o_Tx_DV, bus.o_Tx_Byte}, {1'b1, 8'h01});
        end
        chk("burst count", bus.o_Count, 15);
        chk("burst full", bus.o_Full, 0);
        chk("burst overflow", ovf_seen, 0);
        pulse_done();
        drain(8'h02, 15);
        tick();
        chk("burst busy after done", {bus.o_Busy, bus.o_Empty}, 2'b01);
        // pointer wrap with a write landing on the launch clock
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            wr(8'hE0 + 8'(i));
            if (i == 1) chk("wrap first byte", {bus.o_Tx_DV, bus.o_Tx_Byte}, {1'b1, 8'hE0});
        end
        chk("wrap fill count", bus.o_Count, 14);
        pulse_done();
        drain(8'hE1, 10);
        expect_dv(8'hEB, "wrap EB");
        chk("wrap count 3", bus.o_Count, 3);
        pulse_done();
        tick();
        chk("wrap idle", {bus.o_Tx_DV, bus.o_Count}, {1'b0, 5'd3});
        wr(8'hEF);
        chk("simultaneous", {bus.o_Tx_DV, bus.o_Tx_Byte, bus.o_Count}, {1'b1, 8'hEC, 5'd3});
        wr(8'hF0);
        chk("wrap count 4", bus.o_Count, 4);
        pulse_done();
        drain(8'hED, 4);
        tick();
        chk("wrap drained", {bus.o_Busy, bus.o_Empty}, 2'b01);
        // overflow with the FSM stalled in S_WAIT
        wr(8'h50);
        tick();
        chk("ovf launch", {bus.o_Tx_DV, bus.o_Tx_Byte}, {1'b1, 8'h50});
        for (int i = 0; i < 16; i++) wr(8'h60 + 8'(i));
        chk("ovf filled", act(), pk(0, 8'h50, 16, 0, 1, 1, 0));
        wr(8'hFF);
        chk("ovf pulse", act(), pk(0, 8'h50, 16, 0, 1, 1, 1));
        tick();
        chk("ovf pulse end", act(), pk(0, 8'h50, 16, 0, 1, 1, 0));
        pulse_done();
        tick();
        wr(8'hFE);
        chk("ovf with pop", act(), pk(1, 8'h60, 15, 0, 0, 1, 1));
        pulse_done();
        drain(8'h61, 15);
        no_dv(6, "ovf byte never sent");
        chk("ovf drained", {bus.o_Busy, bus.o_Empty, bus.o_Count}, {2'b01, 5'd0});
        // reset while a byte is in flight
        for (int i = 0; i < 6; i++) wr(8'h70 + 8'(i));
        chk("mid count", act(), pk(0, 8'h70, 5, 0, 0, 1, 0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset", act(), pk(0, 8'h00, 0, 1, 0, 0, 0));
        tick();
        rst_n = 1'b1;
        no_dv(6, "no dv after reset");
        wr(8'h77);
        chk("post reset write", {bus.o_Tx_DV, bus.o_Count}, {1'b0, 5'd1});
        tick();
        chk("post reset launch", {bus.o_Tx_DV, bus.o_Tx_Byte}, {1'b1, 8'h77});
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
